spi_block_loader: RTL and testbench
===================================

SPI_BLOCK_LOADER -- requirements
Module: spi_block_loader

Interface
REQ-001 SHALL have parameter WORDS, default 16, giving the number of 32-bit data words per message block.
REQ-002 SHALL have parameter OP_LOAD, default 8'hA5, the opcode that starts a block load.
REQ-003 SHALL have parameter OP_CLEAR, default 8'hC1, the opcode that clears sticky error flags.
REQ-004 SHALL have port clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, the synchronous active-low reset.
REQ-006 SHALL have port ss, input, 1, the SPI slave select (active low), asynchronous to clk.
REQ-007 SHALL have port spiWord, input, 32, the word shifted in by the upstream SPI slave.
REQ-008 SHALL have port spiDone, input, 1, the upstream word-complete flag, asynchronous to clk.
REQ-009 SHALL have port misoWord, output, 32, the status word returned to the SPI slave for shift-out.
REQ-010 SHALL have port blockData, output, 32*WORDS, the assembled message block.
REQ-011 SHALL have port blockValid, output, 1, asserted while blockData holds a complete block.
REQ-012 SHALL have port blockReady, input, 1, asserted by the downstream MD5 core to accept the block.
REQ-013 SHALL have port overrunErr, output, 1, a one-cycle pulse when a word is dropped.
REQ-014 SHALL have port frameErr, output, 1, a one-cycle pulse on a bad opcode or an aborted frame.

Function
REQ-015 SHALL pass spiDone and ss each through a 2-flop synchronizer; wordStrobe SHALL be the rising edge of synchronized spiDone.
REQ-016 SHALL require fclk >= 8*fsck, so spiWord is captured while it is still stable (it is stable for one sck period after spiDone rises).
REQ-017 SHALL sample spiWord on the clk cycle in which wordStrobe is high.
REQ-018 SHALL assert wordStrobe for the cycle after the third clk edge at which spiDone is sampled high.
REQ-019 SHALL implement the states IDLE=0, LOAD=1 and VALID=2 (2-bit encoding); state 3 SHALL be unreachable and SHALL return to IDLE.
REQ-020 In IDLE, on wordStrobe: if spiWord[31:24]==OP_LOAD, go to LOAD with count=0.
REQ-021 In IDLE, on wordStrobe: if spiWord[31:24]==OP_CLEAR, clear the sticky flags and stay in IDLE.
REQ-022 In IDLE, on wordStrobe with any other opcode: pulse frameErr, set stickyFrame, and stay in IDLE.
REQ-023 In LOAD, each wordStrobe SHALL write spiWord into slot count (slot 0 = blockData MSBs) and SHALL increment count.
REQ-024 In LOAD, the wordStrobe carrying slot WORDS-1 SHALL move the FSM to VALID; blockValid SHALL rise on the next clk edge.
REQ-025 In LOAD, synchronized ss going high before slot WORDS-1 is written SHALL pulse frameErr, set stickyFrame, clear count and go to IDLE.
REQ-026 In LOAD, blockData contents after such an abort are don't-care.
REQ-027 In VALID, blockValid SHALL stay high and blockData SHALL stay stable until a cycle with blockValid&&blockReady.
REQ-028 After the blockValid&&blockReady cycle, blockValid SHALL be low and the state SHALL be IDLE on the next edge.
REQ-029 In VALID, any wordStrobe (including one in the handshake cycle) SHALL drop the word, pulse overrunErr and set stickyOverrun.
REQ-030 In VALID, a wordStrobe SHALL never alter blockData.
REQ-031 The ss level SHALL be ignored in IDLE and in VALID.
REQ-032 count SHALL be $clog2(WORDS)+1 bits wide and SHALL never wrap; it saturates in VALID.
REQ-033 misoWord SHALL be registered every cycle as {8'h4D, 6'b0, state[1:0], 3'b0, count[4:0], 6'b0, stickyOverrun, stickyFrame}.

Reset
REQ-034 When rst_n is low at a clk edge: state=IDLE, count=0, blockData=0, blockValid=0, overrunErr=0, frameErr=0.
REQ-035 When rst_n is low at a clk edge: sticky flags=0, synchronizer flops=0, misoWord=32'h4D00_0000.
REQ-036 Reset mid-LOAD or mid-VALID SHALL discard the partial or pending block with no error pulse.
REQ-037 The spiDone synchronizer flops SHALL clear to 0 on reset, so a spiDone held high across reset release produces no wordStrobe.

Verification
REQ-038 Load: ss low; words 0xA5000000 then 0x00000001..0x00000010; blockReady=1 -> blockValid high for 1 cycle; blockData[511:480]=0x00000001, blockData[31:0]=0x00000010.
REQ-039 Backpressure: full load with blockReady=0 for 50 cycles -> blockValid held, blockData constant; then blockReady=1 for 1 cycle -> state IDLE, misoWord=32'h4D00_1000.
REQ-040 Overrun: an extra word while in VALID -> overrunErr pulses once, blockData unchanged, misoWord[1]=1; then word 0xC1000000 -> misoWord[1:0]=0.
REQ-041 Abort: OP_LOAD plus 5 words, then ss high -> frameErr pulses once, state IDLE, count 0, blockValid never rises.
REQ-042 Bad opcode: word 0x12345678 in IDLE -> frameErr pulse, misoWord[0]=1, state stays IDLE.
REQ-043 Reset: rst_n low for 1 cycle after the 8th data word -> all outputs at reset values; a following complete load succeeds normally.

Source files
------------

// File: rtl/spi_block_loader.sv
// Collects a framed burst of 32-bit SPI words into one message block for the MD5 core
// and reports status through a word that the SPI slave shifts back out.
module spi_block_loader #(
    parameter int unsigned WORDS    = 16,
    parameter logic [7:0]  OP_LOAD  = 8'hA5,
    parameter logic [7:0]  OP_CLEAR = 8'hC1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ss,
    input  logic [31:0]           spiWord,
    input  logic                  spiDone,
    output logic [31:0]           misoWord,
    output logic [32*WORDS-1:0]   blockData,
    output logic                  blockValid,
    input  logic                  blockReady,
    output logic                  overrunErr,
    output logic                  frameErr
);

    localparam int unsigned   CW   = $clog2(WORDS) + 1;
    localparam logic [CW-1:0] LAST = CW'(WORDS - 1);
    localparam logic [CW-1:0] FULL = CW'(WORDS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        VALID = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic          sticky_ovr_q, sticky_ovr_d;
    logic          sticky_frm_q, sticky_frm_d;
    logic          ovr_d, frm_d;
    logic          wr_en;

    logic          done_s1_q, done_s2_q, done_s3_q;
    logic [1:0]    prime_q;
    logic          armed_q;
    logic          strobe_q;
    logic          ss_s1_q, ss_s2_q;
    logic          wordStrobe;

    logic [31:0]   slot_q [WORDS];

    // A rising edge only counts once the synchronized spiDone has been seen low,
    // so a spiDone held high across reset release cannot fake a word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            done_s1_q <= 1'b0;
            done_s2_q <= 1'b0;
            done_s3_q <= 1'b0;
            prime_q   <= '0;
            armed_q   <= 1'b0;
            strobe_q  <= 1'b0;
            ss_s1_q   <= 1'b0;
            ss_s2_q   <= 1'b0;
        end else begin
            done_s1_q <= spiDone;
            done_s2_q <= done_s1_q;
            done_s3_q <= done_s2_q;
            prime_q   <= {prime_q[0], 1'b1};
            if (prime_q[1] && !done_s2_q) begin
                armed_q <= 1'b1;
            end
            strobe_q  <= done_s2_q & ~done_s3_q & armed_q;
            ss_s1_q   <= ss;
            ss_s2_q   <= ss_s1_q;
        end
    end

    assign wordStrobe = strobe_q;

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        sticky_ovr_d = sticky_ovr_q;
        sticky_frm_d = sticky_frm_q;
        ovr_d        = 1'b0;
        frm_d        = 1'b0;
        wr_en        = 1'b0;
        case (state_q)
            IDLE: begin
                if (wordStrobe) begin
                    if (spiWord[31:24] == OP_LOAD) begin
                        state_d = LOAD;
                        count_d = '0;
                    end else if (spiWord[31:24] == OP_CLEAR) begin
                        sticky_ovr_d = 1'b0;
                        sticky_frm_d = 1'b0;
                    end else begin
                        frm_d        = 1'b1;
                        sticky_frm_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (wordStrobe) begin
                    wr_en = 1'b1;
                    if (count_q == LAST) begin
                        state_d = VALID;
                        count_d = FULL;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end else if (ss_s2_q) begin
                    frm_d        = 1'b1;
                    sticky_frm_d = 1'b1;
                    count_d      = '0;
                    state_d      = IDLE;
                end
            end
            VALID: begin
                if (wordStrobe) begin
                    ovr_d        = 1'b1;
                    sticky_ovr_d = 1'b1;
                end
                if (blockReady) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // misoWord is built from next-state values so it tracks the FSM without lag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            count_q      <= '0;
            sticky_ovr_q <= 1'b0;
            sticky_frm_q <= 1'b0;
            overrunErr   <= 1'b0;
            frameErr     <= 1'b0;
            blockValid   <= 1'b0;
            misoWord     <= 32'h4D00_0000;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            sticky_ovr_q <= sticky_ovr_d;
            sticky_frm_q <= sticky_frm_d;
            overrunErr   <= ovr_d;
            frameErr     <= frm_d;
            blockValid   <= (state_d == VALID);
            misoWord     <= {8'h4D, 6'b0, state_d, 3'b0, 5'(count_d),
                             6'b0, sticky_ovr_d, sticky_frm_d};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < WORDS; i++) begin
                slot_q[i] <= '0;
            end
        end else if (wr_en) begin
            for (int unsigned i = 0; i < WORDS; i++) begin
                if (count_q == CW'(i)) begin
                    slot_q[i] <= spiWord;
                end
            end
        end
    end

    always_comb begin
        blockData = '0;
        for (int unsigned i = 0; i < WORDS; i++) begin
            blockData[32*(WORDS-1-i) +: 32] = slot_q[i];
        end
    end

endmodule

// File: tb/tb_spi_block_loader.sv
// Scoreboard bench for spi_block_loader: expected blocks and error pulses are queued
// as stimulus is driven and retired by a monitor when the DUT produces them.
module tb_spi_block_loader;

    localparam int unsigned WORDS = 16;
    localparam int unsigned BW    = 32 * WORDS;

    logic          clk = 1'b0;
    logic          rst_n, ss, spiDone, blockReady;
    logic [31:0]   spiWord, misoWord;
    logic [BW-1:0] blockData;
    logic          blockValid, overrunErr, frameErr;

    always #5 clk = ~clk;

    spi_block_loader #(
        .WORDS   (WORDS),
        .OP_LOAD (8'hA5),
        .OP_CLEAR(8'hC1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ss        (ss),
        .spiWord   (spiWord),
        .spiDone   (spiDone),
        .misoWord  (misoWord),
        .blockData (blockData),
        .blockValid(blockValid),
        .blockReady(blockReady),
        .overrunErr(overrunErr),
        .frameErr  (frameErr)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    logic [BW-1:0] exp_blk[$];
    logic [1:0]    exp_err[$];
    int            run_len  = 0;
    int            last_run = 0;
    logic [BW-1:0] last_blk = '0;

    always @(negedge clk) begin
        if (blockValid === 1'b1) run_len++;
        else if (run_len != 0) begin
            last_run = run_len;
            run_len  = 0;
        end
        if (blockValid === 1'b1 && blockReady === 1'b1) begin
            last_blk = blockData;
            if (exp_blk.size() == 0) check("blk_unexp", BW'(blockValid), '0);
            else check("block", blockData, exp_blk.pop_front());
        end
        if (overrunErr === 1'b1 || frameErr === 1'b1) begin
            if (exp_err.size() == 0) check("err_unexp", BW'({overrunErr, frameErr}), '0);
            else check("err", BW'({overrunErr, frameErr}), BW'(exp_err.pop_front()));
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic send_word(input logic [31:0] w);
        spiWord = w;
        spiDone = 1'b1;
        cyc(6);
        spiDone = 1'b0;
        cyc(6);
    endtask

    function automatic logic [BW-1:0] mk_blk(input logic [31:0] base);
        logic [BW-1:0] b;
        b = '0;
        for (int i = 0; i < int'(WORDS); i++) b[BW-1-32*i -: 32] = base + 32'(i);
        return b;
    endfunction

    task automatic load_block(input logic [31:0] base);
        send_word(32'hA500_0000);
        for (int i = 0; i < int'(WORDS); i++) send_word(base + 32'(i));
    endtask

    task automatic wait_valid(input int budget);
        int k;
        k = 0;
        while (blockValid !== 1'b1 && k < budget) begin
            cyc(1);
            k++;
        end
        check("valid_wait", BW'(blockValid), BW'(1'b1));
    endtask

    logic [BW-1:0] d0;

    initial begin
        rst_n = 1'b0; ss = 1'b0; spiDone = 1'b1; spiWord = 32'h1234_5678; blockReady = 1'b0;
        cyc(3);
        check("rst_miso", BW'(misoWord), BW'(32'h4D00_0000));
        check("rst_valid", BW'(blockValid), '0);
        check("rst_data", blockData, '0);
        check("rst_errs", BW'({overrunErr, frameErr}), '0);

        // spiDone high across release must not look like a word
        rst_n = 1'b1;
        cyc(10);
        check("rel_miso", BW'(misoWord), BW'(32'h4D00_0000));
        spiDone = 1'b0;
        cyc(4);

        // basic load with blockReady high
        blockReady = 1'b1;
        exp_blk.push_back(mk_blk(32'h0000_0001));
        send_word(32'hA500_0000);
        check("load_miso", BW'(misoWord), BW'(32'h4D01_0000));
        for (int i = 0; i < int'(WORDS); i++) send_word(32'h0000_0001 + 32'(i));
        cyc(4);
        check("load_run", BW'(last_run), BW'(1));
        check("load_msw", BW'(last_blk[BW-1 -: 32]), BW'(32'h0000_0001));
        check("load_lsw", BW'(last_blk[31:0]), BW'(32'h0000_0010));
        check("load_idle_miso", BW'(misoWord), BW'(32'h4D00_1000));

        // backpressure
        blockReady = 1'b0;
        exp_blk.push_back(mk_blk(32'h0000_0100));
        load_block(32'h0000_0100);
        wait_valid(20);
        d0 = blockData;
        cyc(50);
        check("bp_valid", BW'(blockValid), BW'(1'b1));
        check("bp_stable", blockData, mk_blk(32'h0000_0100));
        check("bp_miso", BW'(misoWord), BW'(32'h4D02_1000));
        blockReady = 1'b1;
        cyc(1);
        blockReady = 1'b0;
        check("bp_valid_low", BW'(blockValid), '0);
        check("bp_done_miso", BW'(misoWord), BW'(32'h4D00_1000));
        check("bp_hold", d0, mk_blk(32'h0000_0100));

        // overrun while a block is pending
        exp_blk.push_back(mk_blk(32'h0000_A000));
        load_block(32'h0000_A000);
        wait_valid(20);
        exp_err.push_back(2'b10);
        send_word(32'hDEAD_BEEF);
        check("ovr_miso", BW'(misoWord), BW'(32'h4D02_1002));
        check("ovr_data", blockData, mk_blk(32'h0000_A000));
        blockReady = 1'b1;
        cyc(1);
        blockReady = 1'b0;
        send_word(32'hC100_0000);
        check("ovr_clr_miso", BW'(misoWord), BW'(32'h4D00_1000));
        check("ovr_pending", BW'(exp_err.size()), '0);

        // abort mid-frame
        blockReady = 1'b1;
        send_word(32'hA500_0000);
        for (int i = 0; i < 5; i++) send_word(32'h0000_0050 + 32'(i));
        exp_err.push_back(2'b01);
        ss = 1'b1;
        cyc(6);
        check("abort_miso", BW'(misoWord), BW'(32'h4D00_0001));
        check("abort_valid", BW'(blockValid), '0);
        check("abort_pending", BW'(exp_err.size()), '0);
        ss = 1'b0;
        send_word(32'hC100_0000);
        check("abort_clr_miso", BW'(misoWord), BW'(32'h4D00_0000));

        // bad opcode
        exp_err.push_back(2'b01);
        send_word(32'h1234_5678);
        check("bad_miso", BW'(misoWord), BW'(32'h4D00_0001));
        check("bad_pending", BW'(exp_err.size()), '0);
        send_word(32'hC100_0000);
        check("bad_clr_miso", BW'(misoWord), BW'(32'h4D00_0000));

        // reset after the 8th data word, then a clean load
        send_word(32'hA500_0000);
        for (int i = 0; i < 8; i++) send_word(32'h0000_0300 + 32'(i));
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        check("mid_rst_miso", BW'(misoWord), BW'(32'h4D00_0000));
        check("mid_rst_valid", BW'(blockValid), '0);
        check("mid_rst_data", blockData, '0);
        check("mid_rst_errs", BW'({overrunErr, frameErr}), '0);
        cyc(4);
        exp_blk.push_back(mk_blk(32'h0000_7000));
        load_block(32'h0000_7000);
        cyc(4);
        check("post_rst_miso", BW'(misoWord), BW'(32'h4D00_1000));
        check("post_rst_run", BW'(last_run), BW'(1));

        check("blk_pending", BW'(exp_blk.size()), '0);
        check("err_pending", BW'(exp_err.size()), '0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
